// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM state encoding and result-source selects
package pipeline_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, MD_WAIT} state_t;
  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS = 2'b10;
  localparam logic [1:0] LUI_AUIPC = 2'b11;
  localparam int REM_W = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  // clear beats increment; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard stall/flush control; mul/div handshake enabled by PIPELINE_CTRL_MULDIV_EN
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_muldiv,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_regfile_wr_enable,
  input  logic             ex_pc_src,
  input  logic             dmem_ready,
  input  logic             muldiv_done,
  input  logic             perf_clear,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             muldiv_start,
  output logic [CNT_W-1:0] stall_count
);
`ifdef PIPELINE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  state_t state, nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic hold, bubble, flush, start, load_use;
  assign load_use = ex_regfile_wr_enable && ex_result_src == MEM_TO_REG && ex_rd != '0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  // state and flush-remaining registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      rem <= '0;
    end else begin
      state <= nxt;
      rem <= rem_nxt;
    end
  // next state and control: memory hold first, then flush, mul/div wait, redirect, load-use, mul/div launch
  always_comb begin
    nxt = state;
    rem_nxt = rem;
    hold = 1'b0;
    bubble = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    if (!rst_n) nxt = RUN;
    else if (!dmem_ready) hold = 1'b1;
    else
      case (state)
        FLUSH: begin
          flush = 1'b1;
          rem_nxt = rem - REM_W'(1);
          nxt = rem == REM_W'(1) ? RUN : FLUSH;
        end
        MD_WAIT: begin
          bubble = MD_EN && !muldiv_done;
          nxt = MD_EN && !muldiv_done ? MD_WAIT : RUN;
        end
        default: begin
          if (ex_pc_src) begin
            flush = 1'b1;
            nxt = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            rem_nxt = FLUSH_CYCLES > 1 ? REM_W'(FLUSH_CYCLES - 1) : rem;
          end else if (load_use) bubble = 1'b1;
          else if (MD_EN && id_muldiv) begin
            bubble = 1'b1;
            start = 1'b1;
            nxt = MD_WAIT;
          end
        end
      endcase
  end
  assign stall_if = hold | bubble;
  assign stall_id = hold | bubble;
  assign stall_ex = hold;
  assign flush_id = flush;
  assign flush_ex = flush | bubble;
  assign muldiv_start = start;
  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .inc(stall_if),
    .clear(perf_clear),
    .count(stall_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized scoreboard bench for pipeline_ctrl with a behavioural model
module tb_pipeline_ctrl;
  localparam int FC = 3;
  localparam int CW = 4;
`ifdef PIPELINE_CTRL_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_muldiv, ex_regfile_wr_enable, ex_pc_src;
  logic [1:0] ex_result_src;
  logic dmem_ready, muldiv_done, perf_clear;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, muldiv_start;
  logic [CW-1:0] stall_count;
  typedef struct {
    int cyc;
    logic [5:0] f;
    logic [CW-1:0] c;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int flush_left = 0;
  bit md_busy = 0;
  int cnt = 0;
  pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_muldiv(id_muldiv), .ex_rd(ex_rd), .ex_result_src(ex_result_src),
    .ex_regfile_wr_enable(ex_regfile_wr_enable), .ex_pc_src(ex_pc_src),
    .dmem_ready(dmem_ready), .muldiv_done(muldiv_done), .perf_clear(perf_clear),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .muldiv_start(muldiv_start),
    .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_muldiv = 0;
    ex_result_src = 0; ex_regfile_wr_enable = 0; ex_pc_src = 0;
    dmem_ready = 1; muldiv_done = 0; perf_clear = 0; rst_n = 1;
  endtask
  task automatic step();
    exp_t e;
    bit lu, si, sd, se, fi, fe, ms;
    lu = ex_regfile_wr_enable && ex_result_src == 2'b01 && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {si, sd, se, fi, fe, ms} = '0;
    if (!rst_n) begin
      flush_left = 0; md_busy = 0; cnt = 0;
    end else if (!dmem_ready) {si, sd, se} = 3'b111;
    else if (flush_left > 0) begin
      fi = 1; fe = 1; flush_left--;
    end else if (md_busy) begin
      if (muldiv_done) md_busy = 0;
      else begin si = 1; sd = 1; fe = 1; end
    end else if (ex_pc_src) begin
      fi = 1; fe = 1; flush_left = FC - 1;
    end else if (lu) begin
      si = 1; sd = 1; fe = 1;
    end else if (MD && id_muldiv) begin
      si = 1; sd = 1; fe = 1; ms = 1; md_busy = 1;
    end
    e.cyc = cyc;
    e.f = {si, sd, se, fi, fe, ms};
    e.c = CW'(cnt);
    q.push_back(e);
    if (rst_n) cnt = perf_clear ? 0 : (si && cnt < (1 << CW) - 1) ? cnt + 1 : cnt;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {stall_if, stall_id, stall_ex, flush_id, flush_ex, muldiv_start};
      checks++;
      if (got !== e.f) $display("FAIL outs cyc=%0d got=%b exp=%b", e.cyc, got, e.f);
      else passed++;
      checks++;
      if (stall_count !== e.c) $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", e.cyc, stall_count, e.c);
      else passed++;
    end
  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    repeat (2) step();
    idle();
    repeat (2) step();
    ex_result_src = 2'b01; ex_rd = 5; ex_regfile_wr_enable = 1; id_rs1 = 5; id_uses_rs1 = 1;
    step();
    idle();
    step();
    ex_result_src = 2'b01; ex_rd = 0; ex_regfile_wr_enable = 1; id_rs1 = 0; id_uses_rs1 = 1;
    step();
    idle();
    ex_pc_src = 1; ex_result_src = 2'b01; ex_rd = 7; ex_regfile_wr_enable = 1; id_rs2 = 7; id_uses_rs2 = 1;
    step();
    ex_pc_src = 1;
    repeat (2) step();
    idle();
    repeat (2) step();
    id_muldiv = 1;
    step();
    idle();
    repeat (3) step();
    muldiv_done = 1;
    step();
    idle();
    step();
    id_muldiv = 1;
    step();
    idle();
    step();
    dmem_ready = 0;
    repeat (2) step();
    dmem_ready = 1;
    repeat (2) step();
    muldiv_done = 1;
    step();
    idle();
    id_muldiv = 1;
    step();
    idle();
    repeat (2) step();
    rst_n = 0;
    step();
    idle();
    repeat (3) step();
    dmem_ready = 0;
    repeat (20) step();
    perf_clear = 1;
    step();
    idle();
    repeat (2) step();
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 99) >= 2;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom);
      id_uses_rs2 = 1'($urandom);
      ex_result_src = 2'($urandom);
      ex_regfile_wr_enable = 1'($urandom);
      ex_pc_src = $urandom_range(0, 9) == 0;
      id_muldiv = $urandom_range(0, 6) == 0;
      muldiv_done = $urandom_range(0, 3) == 0;
      dmem_ready = $urandom_range(0, 9) >= 2;
      perf_clear = $urandom_range(0, 99) < 3;
      step();
    end
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) $display("FAIL drain left=%0d exp=0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
